i2s_tx_fifo: RTL



---
 rtl/i2s_tx_fifo.sv | 102 ++++++++++
 1 files changed

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - first-word-fall-through sample FIFO between the APB register block and the I2S serializer
module i2s_tx_fifo #(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 8,
  parameter  int AF_THRESH = 6,
  parameter  int AE_THRESH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          clr,
  input  logic          flag_clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_THRESH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic push, pop, ovf_evt, udf_evt;

  assign full         = (level_q == DEPTH_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_data      = empty ? '0 : mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!clr) begin
      push    = wr_en & (~full | rd_en);
      pop     = rd_en & ~empty;
      ovf_evt = wr_en & full & ~rd_en;
      udf_evt = rd_en & empty;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = ovf_evt | (overflow_q & ~flag_clr);
    underflow_d = udf_evt | (underflow_q & ~flag_clr);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample storage carries no reset; rd_data is masked while empty instead.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule
